// File: rtl/grf_wb.sv
// grf_wb -- writeback-side general register file for the 5-stage MIPS pipeline.
//
// Takes the W-stage decoder controls (reg_write, reg_addr_op, reg_data_op)
// and the W-stage datapath values. It resolves the destination register and
// the write data, then commits them into a 32x32 register file. It serves the
// two D-stage read ports with a same-cycle write-through bypass. It also
// exports the committed write for forwarding, counts retired instructions,
// and emits a one-cycle-delayed commit trace.
//
// Ports:
//   clk, rst_n            clock (rising edge); asynchronous active-low reset
//   wb_valid              W stage holds a real instruction (0 = bubble)
//   reg_write             decoder write request
//   reg_addr_op           0=rd, 1=rt, 2=$31, other=no destination
//   reg_data_op           0=alu, 1=dm, 2=imm<<16, 3=pc+8, other=0
//   rt_W, rd_W, imm_W     instruction fields in W
//   pc_W, alu_out_W,
//   dm_out_W              W-stage datapath values
//   rs_addr_D, rt_addr_D  D-stage read addresses
//   rs_data_D, rt_data_D  D-stage read data (combinational, bypassed)
//   wb_en/addr/data       committed write this cycle (zero when idle)
//   retire_cnt            retired-instruction counter (wraps)
//   trace_*               registered copy of last cycle's commit
module grf_wb #(
  parameter int CNT_W    = 32,
  parameter bit TRACE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic             reg_write,
  input  logic [2:0]       reg_addr_op,
  input  logic [2:0]       reg_data_op,
  input  logic [4:0]       rt_W,
  input  logic [4:0]       rd_W,
  input  logic [15:0]      imm_W,
  input  logic [31:0]      pc_W,
  input  logic [31:0]      alu_out_W,
  input  logic [31:0]      dm_out_W,
  input  logic [4:0]       rs_addr_D,
  input  logic [4:0]       rt_addr_D,
  output logic [31:0]      rs_data_D,
  output logic [31:0]      rt_data_D,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             trace_valid,
  output logic [31:0]      trace_pc,
  output logic [4:0]       trace_addr,
  output logic [31:0]      trace_data
);

  logic [4:0]       dest_addr;
  logic             dest_ok;
  logic [31:0]      dest_data;
  logic             trace_load;

  logic [31:0]      regs_reg [32];
  logic [CNT_W-1:0] retire_cnt_reg;
  logic             trace_valid_reg;
  logic [31:0]      trace_pc_reg;
  logic [4:0]       trace_addr_reg;
  logic [31:0]      trace_data_reg;

  // Destination register select.
  always_comb begin
    dest_addr = 5'd0;
    dest_ok   = 1'b0;
    case (reg_addr_op)
      3'd0: begin dest_addr = rd_W;  dest_ok = 1'b1; end
      3'd1: begin dest_addr = rt_W;  dest_ok = 1'b1; end
      3'd2: begin dest_addr = 5'd31; dest_ok = 1'b1; end
      default: begin dest_addr = 5'd0; dest_ok = 1'b0; end
    endcase
  end

  // Write data select; pc+8 wraps naturally in 32 bits.
  always_comb begin
    dest_data = 32'h0;
    case (reg_data_op)
      3'd0:    dest_data = alu_out_W;
      3'd1:    dest_data = dm_out_W;
      3'd2:    dest_data = {imm_W, 16'h0};
      3'd3:    dest_data = pc_W + 32'd8;
      default: dest_data = 32'h0;
    endcase
  end

  // wb_valid is the first AND term, so X on the op fields during a bubble
  // cannot leak into wb_en. wb_addr/wb_data are then forced to zero.
  assign wb_en   = wb_valid & reg_write & dest_ok & (dest_addr != 5'd0);
  assign wb_addr = wb_en ? dest_addr : 5'd0;
  assign wb_data = wb_en ? dest_data : 32'h0;

  // Reads: $0 is hardwired to zero; a same-cycle commit wins over storage.
  assign rs_data_D = (rs_addr_D == 5'd0)                 ? 32'h0   :
                     (wb_en && (rs_addr_D == wb_addr))   ? wb_data :
                                                           regs_reg[rs_addr_D];
  assign rt_data_D = (rt_addr_D == 5'd0)                 ? 32'h0   :
                     (wb_en && (rt_addr_D == wb_addr))   ? wb_data :
                                                           regs_reg[rt_addr_D];

  // Register storage. Entry 0 is cleared on reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_reg[i] <= 32'h0;
      end
    end else if (wb_en) begin
      regs_reg[wb_addr] <= wb_data;
    end
  end

  // Retired-instruction counter: every real instruction counts, whether it
  // writes or not (stores, branches, writes to $0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_reg <= '0;
    end else if (wb_valid) begin
      retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
    end
  end

  // Commit trace: loads every edge, so it shows exactly one cycle behind.
  assign trace_load = wb_en & TRACE_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_valid_reg <= 1'b0;
      trace_pc_reg    <= 32'h0;
      trace_addr_reg  <= 5'd0;
      trace_data_reg  <= 32'h0;
    end else begin
      trace_valid_reg <= trace_load;
      trace_pc_reg    <= trace_load ? pc_W    : 32'h0;
      trace_addr_reg  <= trace_load ? wb_addr : 5'd0;
      trace_data_reg  <= trace_load ? wb_data : 32'h0;
    end
  end

  assign retire_cnt  = retire_cnt_reg;
  assign trace_valid = trace_valid_reg;
  assign trace_pc    = trace_pc_reg;
  assign trace_addr  = trace_addr_reg;
  assign trace_data  = trace_data_reg;

endmodule

// File: tb/tb_grf_wb.sv
// Directed testbench for grf_wb. A second instance with a 3-bit counter and
// the trace disabled shares the same stimulus. It exercises the counter wrap
// and the trace-off behaviour.
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, reg_write;
  logic [2:0]  reg_addr_op, reg_data_op;
  logic [4:0]  rt_W, rd_W, rs_addr_D, rt_addr_D;
  logic [15:0] imm_W;
  logic [31:0] pc_W, alu_out_W, dm_out_W;

  logic [31:0] rs_data_D, rt_data_D, wb_data, trace_pc, trace_data;
  logic        wb_en, trace_valid;
  logic [4:0]  wb_addr, trace_addr;
  logic [31:0] retire_cnt;

  logic [31:0] s_rs_data, s_rt_data, s_wb_data, s_trace_pc, s_trace_data;
  logic        s_wb_en, s_trace_valid;
  logic [4:0]  s_wb_addr, s_trace_addr;
  logic [2:0]  s_retire_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  grf_wb #(.CNT_W(32), .TRACE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .reg_write(reg_write),
    .reg_addr_op(reg_addr_op), .reg_data_op(reg_data_op), .rt_W(rt_W),
    .rd_W(rd_W), .imm_W(imm_W), .pc_W(pc_W), .alu_out_W(alu_out_W),
    .dm_out_W(dm_out_W), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .rs_data_D(rs_data_D), .rt_data_D(rt_data_D), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .retire_cnt(retire_cnt),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data)
  );

  grf_wb #(.CNT_W(3), .TRACE_EN(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .reg_write(reg_write),
    .reg_addr_op(reg_addr_op), .reg_data_op(reg_data_op), .rt_W(rt_W),
    .rd_W(rd_W), .imm_W(imm_W), .pc_W(pc_W), .alu_out_W(alu_out_W),
    .dm_out_W(dm_out_W), .rs_addr_D(rs_addr_D), .rt_addr_D(rt_addr_D),
    .rs_data_D(s_rs_data), .rt_data_D(s_rt_data), .wb_en(s_wb_en),
    .wb_addr(s_wb_addr), .wb_data(s_wb_data), .retire_cnt(s_retire_cnt),
    .trace_valid(s_trace_valid), .trace_pc(s_trace_pc),
    .trace_addr(s_trace_addr), .trace_data(s_trace_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic rw, input logic [2:0] aop,
                     input logic [2:0] dop, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [15:0] imm, input logic [31:0] pc,
                     input logic [31:0] alu, input logic [31:0] dm);
    wb_valid = v;  reg_write = rw; reg_addr_op = aop; reg_data_op = dop;
    rt_W = rt; rd_W = rd; imm_W = imm; pc_W = pc; alu_out_W = alu; dm_out_W = dm;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 3'd0, 3'd0, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rs_addr_D = 5'd0;
    rt_addr_D = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state: every address reads 0 on both ports.
    for (int i = 0; i < 32; i++) begin
      rs_addr_D = 5'(i);
      rt_addr_D = 5'(31 - i);
      #1;
      chk($sformatf("reset_rs_%0d", i), rs_data_D, 32'h0);
      chk($sformatf("reset_rt_%0d", 31 - i), rt_data_D, 32'h0);
    end
    chk("reset_cnt", retire_cnt, 32'h0);
    chk("reset_trace_valid", {31'h0, trace_valid}, 32'h0);
    $display("step reset: checked 32 addresses, counter, trace");
    tick();

    // ALU write to rd=8 with bypass on both ports.
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd3, 5'd8, 16'h0, 32'h0000_0100, 32'h1234_5678, 32'h0);
    rs_addr_D = 5'd8; rt_addr_D = 5'd8;
    #1;
    chk("alu_bypass_rs", rs_data_D, 32'h1234_5678);
    chk("alu_bypass_rt", rt_data_D, 32'h1234_5678);
    chk("alu_wb_en", {31'h0, wb_en}, 32'h1);
    chk("alu_wb_addr", {27'h0, wb_addr}, 32'd8);
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    tick();
    idle();
    #1;
    chk("alu_stored", rs_data_D, 32'h1234_5678);
    chk("alu_trace_valid", {31'h0, trace_valid}, 32'h1);
    chk("alu_trace_addr", {27'h0, trace_addr}, 32'd8);
    chk("alu_trace_pc", trace_pc, 32'h0000_0100);
    chk("alu_trace_data", trace_data, 32'h1234_5678);
    chk("alu_cnt", retire_cnt, 32'd1);
    chk("small_trace_off", {31'h0, s_trace_valid}, 32'h0);
    $display("step alu: r8 <= 12345678");

    // jal then lui back to back.
    drv(1'b1, 1'b1, 3'd2, 3'd3, 5'd0, 5'd0, 16'h0, 32'h0000_3000, 32'h0, 32'h0);
    #1;
    chk("jal_wb_addr", {27'h0, wb_addr}, 32'd31);
    chk("jal_wb_data", wb_data, 32'h0000_3008);
    tick();
    drv(1'b1, 1'b1, 3'd1, 3'd2, 5'd5, 5'd9, 16'hABCD, 32'h0000_3004, 32'h0, 32'h0);
    #1;
    chk("jal_trace_valid", {31'h0, trace_valid}, 32'h1);
    chk("jal_trace_addr", {27'h0, trace_addr}, 32'd31);
    chk("jal_trace_data", trace_data, 32'h0000_3008);
    tick();
    idle();
    rs_addr_D = 5'd31; rt_addr_D = 5'd5;
    #1;
    chk("jal_stored", rs_data_D, 32'h0000_3008);
    chk("lui_stored", rt_data_D, 32'hABCD_0000);
    chk("lui_trace_valid", {31'h0, trace_valid}, 32'h1);
    chk("lui_trace_addr", {27'h0, trace_addr}, 32'd5);
    chk("lui_trace_pc", trace_pc, 32'h0000_3004);
    chk("lui_cnt", retire_cnt, 32'd3);
    $display("step jal/lui: r31 <= 00003008, r5 <= abcd0000");

    // Write targeting $0 is dropped but still retires.
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd0, 5'd0, 16'h0, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0);
    rs_addr_D = 5'd0;
    #1;
    chk("zero_wb_en", {31'h0, wb_en}, 32'h0);
    chk("zero_wb_addr", {27'h0, wb_addr}, 32'h0);
    chk("zero_wb_data", wb_data, 32'h0);
    chk("zero_read_now", rs_data_D, 32'h0);
    tick();
    idle();
    #1;
    chk("zero_read_after", rs_data_D, 32'h0);
    chk("zero_no_trace", {31'h0, trace_valid}, 32'h0);
    chk("zero_cnt", retire_cnt, 32'd4);
    $display("step $0: write dropped, count 4");

    // Ten-cycle mix: seven with wb_valid=1.
    // c1 lw r10 <= dm, rs bypass on r10 and rt from stored r8
    drv(1'b1, 1'b1, 3'd1, 3'd1, 5'd10, 5'd0, 16'h0, 32'h0000_5000, 32'h0, 32'hCAFE_BABE);
    rs_addr_D = 5'd10; rt_addr_D = 5'd8;
    #1;
    chk("lw_bypass_rs", rs_data_D, 32'hCAFE_BABE);
    chk("lw_other_rt", rt_data_D, 32'h1234_5678);
    tick();
    chk("lw_cnt", retire_cnt, 32'd5);
    // c2 bubble with X controls
    drv(1'b0, 1'b1, 3'bxxx, 3'bxxx, 5'd1, 5'd1, 16'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("bubx_wb_en", {31'h0, wb_en}, 32'h0);
    chk("bubx_wb_addr", {27'h0, wb_addr}, 32'h0);
    chk("bubx_wb_data", wb_data, 32'h0);
    tick();
    chk("bubx_cnt", retire_cnt, 32'd5);
    chk("bubx_trace", {31'h0, trace_valid}, 32'h0);
    // c3 sw (no write)
    drv(1'b1, 1'b0, 3'd1, 3'd1, 5'd8, 5'd0, 16'h0, 32'h0, 32'h0, 32'h5555_5555);
    #1;
    chk("sw_wb_en", {31'h0, wb_en}, 32'h0);
    tick();
    // c4 beq (no write, no destination)
    drv(1'b1, 1'b0, 3'd7, 3'd7, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("beq_cnt", retire_cnt, 32'd7);
    chk("small_cnt_7", {29'h0, s_retire_cnt}, 32'd7);
    // c5 bubble
    idle();
    tick();
    // c6 reg_write with no-destination addr op
    drv(1'b1, 1'b1, 3'd3, 3'd0, 5'd20, 5'd20, 16'h0, 32'h0, 32'h5, 32'h0);
    #1;
    chk("nodest_wb_en", {31'h0, wb_en}, 32'h0);
    tick();
    chk("small_cnt_wrap", {29'h0, s_retire_cnt}, 32'd0);
    // c7 undefined data op -> writes 0 into r11
    drv(1'b1, 1'b1, 3'd0, 3'd5, 5'd0, 5'd11, 16'h0, 32'h0000_6000, 32'h77, 32'h0);
    #1;
    chk("dop5_wb_en", {31'h0, wb_en}, 32'h1);
    chk("dop5_wb_data", wb_data, 32'h0);
    tick();
    chk("dop5_trace_addr", {27'h0, trace_addr}, 32'd11);
    chk("dop5_trace_pc", trace_pc, 32'h0000_6000);
    chk("small_trace_pc_off", s_trace_pc, 32'h0);
    // c8 bubble with X controls
    drv(1'b0, 1'b1, 3'bxxx, 3'bxxx, 5'd8, 5'd8, 16'h0, 32'h0, 32'hDEAD_DEAD, 32'hDEAD_DEAD);
    tick();
    // c9 commit r12
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd0, 5'd12, 16'h0, 32'h0000_7000, 32'h0000_1111, 32'h0);
    tick();
    // c10 sw-like retire without write
    drv(1'b1, 1'b0, 3'd0, 3'd0, 5'd0, 5'd13, 16'h0, 32'h0, 32'h9999, 32'h0);
    tick();
    idle();
    rs_addr_D = 5'd8; rt_addr_D = 5'd10;
    #1;
    chk("mix_cnt", retire_cnt, 32'd11);
    chk("mix_small_cnt", {29'h0, s_retire_cnt}, 32'd3);
    chk("mix_r8_intact", rs_data_D, 32'h1234_5678);
    chk("mix_r10", rt_data_D, 32'hCAFE_BABE);
    $display("step mix: count 11, small count 3");

    // Reset asserted mid-cycle between two commits.
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd0, 5'd14, 16'h0, 32'h0000_8000, 32'h0000_AAAA, 32'h0);
    tick();
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd0, 5'd13, 16'h0, 32'h0000_8004, 32'h0000_2222, 32'h0);
    rs_addr_D = 5'd14; rt_addr_D = 5'd12;
    #1;
    chk("pre_rst_r14", rs_data_D, 32'h0000_AAAA);
    chk("pre_rst_trace", {31'h0, trace_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_r14", rs_data_D, 32'h0);
    chk("rst_async_r12", rt_data_D, 32'h0);
    chk("rst_async_cnt", retire_cnt, 32'h0);
    chk("rst_async_trace_valid", {31'h0, trace_valid}, 32'h0);
    chk("rst_async_trace_pc", trace_pc, 32'h0);
    tick();
    idle();
    rs_addr_D = 5'd13;
    #1;
    chk("rst_edge_r13_lost", rs_data_D, 32'h0);
    chk("rst_edge_trace", {31'h0, trace_valid}, 32'h0);
    chk("rst_edge_cnt", retire_cnt, 32'h0);
    #2 rst_n = 1'b1;
    // First edge after release commits.
    drv(1'b1, 1'b1, 3'd0, 3'd0, 5'd0, 5'd15, 16'h0, 32'h0000_9000, 32'h0000_3333, 32'h0);
    tick();
    idle();
    rs_addr_D = 5'd15;
    #1;
    chk("post_rst_r15", rs_data_D, 32'h0000_3333);
    chk("post_rst_cnt", retire_cnt, 32'd1);
    chk("post_rst_trace_addr", {27'h0, trace_addr}, 32'd15);
    $display("step reset-mid: state cleared, r13 lost, r15 committed");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
